// File: rtl/usb_rx_framer_pkg.sv
// Shared definitions for the receive-side frame builder.
// Holds the framer state encoding, the default start-of-frame marker and a
// helper that sizes the per-word / per-length byte index counter.
package usb_rx_framer_pkg;

    // Framer sequencing states, in frame emission order.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StInfo = 3'd1,
        StSync = 3'd2,
        StStat = 3'd3,
        StLen  = 3'd4,
        StData = 3'd5,
        StChk  = 3'd6,
        StDone = 3'd7
    } framer_state_e;

    localparam logic [7:0] SyncByteDefault = 8'hA5;

    // Byte index width for n bytes; at least one bit so the counter always exists.
    function automatic int unsigned byte_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// Frame byte selector.
// Picks the byte to place on the Tx path from the current framer state, the
// latched status/length fields, the payload word, the running checksum and the
// byte index within the current multi-byte field. Outputs 8'h00 outside the
// byte-emitting states.
// Ports:
//   i_state     current framer state
//   i_status    latched status byte
//   i_length    latched length in words
//   i_byte_idx  byte index within the length field or payload word
//   i_data      payload word (MSB byte is sent first)
//   i_chk       running XOR checksum
//   o_byte      selected Tx byte
module frame_byte_mux
    import usb_rx_framer_pkg::*;
#(
    parameter int unsigned BPW       = 1,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned BIDX_W    = 1,
    parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
    input  framer_state_e       i_state,
    input  logic [7:0]          i_status,
    input  logic [LEN_W-1:0]    i_length,
    input  logic [BIDX_W-1:0]   i_byte_idx,
    input  logic [8*BPW-1:0]    i_data,
    input  logic [7:0]          i_chk,
    output logic [7:0]          o_byte
);

    localparam int unsigned LenBytes = LEN_W / 8;

    logic [7:0] w_len_byte;
    logic [7:0] w_data_byte;

    // Index 0 addresses the most significant byte of each field.
    always_comb begin
        w_len_byte = 8'h00;
        for (int i = 0; i < int'(LenBytes); i++) begin
            if (i_byte_idx == BIDX_W'(i)) begin
                w_len_byte = i_length[8*(int'(LenBytes)-1-i) +: 8];
            end
        end
    end

    always_comb begin
        w_data_byte = 8'h00;
        for (int i = 0; i < int'(BPW); i++) begin
            if (i_byte_idx == BIDX_W'(i)) begin
                w_data_byte = i_data[8*(int'(BPW)-1-i) +: 8];
            end
        end
    end

    always_comb begin
        o_byte = 8'h00;
        case (i_state)
            StSync:  o_byte = SYNC_BYTE;
            StStat:  o_byte = i_status;
            StLen:   o_byte = w_len_byte;
            StData:  o_byte = w_data_byte;
            StChk:   o_byte = i_chk;
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/usb_rx_framer.sv
// Receive frame builder.
// On a start request with packet info available, pops one info word and emits
// SYNC_BYTE, status, length (MSB first), the payload (each word MSB byte first)
// and optionally an XOR checksum into a byte-wide Tx FIFO, one byte per cycle,
// pausing whenever the Tx FIFO is full or the payload FIFO is empty.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 one-cycle frame request (ignored while busy)
//   o_busy, o_done          frame in progress / one-cycle completion pulse
//   i_info_data/_empty      FWFT info FIFO (status byte on top, length at bottom)
//   o_info_re               info FIFO pop
//   i_data/_empty, o_data_re  FWFT payload FIFO and its pop
//   i_tx_full               Tx FIFO full
//   o_tx_data, o_tx_send    Tx byte and write strobe
module usb_rx_framer
    import usb_rx_framer_pkg::*;
#(
    parameter int unsigned BPW       = 1,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned INFO_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = SyncByteDefault,
    parameter bit          CHK_EN    = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    input  logic [INFO_W-1:0]   i_info_data,
    input  logic                i_info_empty,
    output logic                o_info_re,
    input  logic [8*BPW-1:0]    i_data,
    input  logic                i_data_empty,
    output logic                o_data_re,
    input  logic                i_tx_full,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_send
);

    localparam int unsigned LenBytes = LEN_W / 8;
    localparam int unsigned BidxW    = byte_idx_width((BPW > LenBytes) ? BPW : LenBytes);

    localparam logic [BidxW-1:0] LastWordByte = BidxW'(BPW - 1);
    localparam logic [BidxW-1:0] LastLenByte  = BidxW'(LenBytes - 1);
    localparam logic [BidxW-1:0] IdxOne       = BidxW'(1);
    localparam logic [LEN_W-1:0] OneWord      = LEN_W'(1);

    // Where sequencing goes once the payload (or an empty payload) is finished.
    localparam framer_state_e AfterPayload = CHK_EN ? StChk : StDone;

    framer_state_e      r_state;
    framer_state_e      w_next_state;

    logic [7:0]         r_status;
    logic [LEN_W-1:0]   r_length;
    logic [LEN_W-1:0]   r_words_left;
    logic [BidxW-1:0]   r_byte_idx;
    logic [7:0]         r_chk;

    logic [7:0]         w_tx_byte;
    logic               w_emit;
    logic               w_send;
    logic               w_last_word_byte;
    logic               w_last_len_byte;
    logic               w_last_word;
    logic               w_unused_info;

    // Bits between the length field and the status byte carry nothing here.
    assign w_unused_info = ^i_info_data;

    assign w_emit = (r_state == StSync) || (r_state == StStat) || (r_state == StLen) ||
                    (r_state == StData) || (r_state == StChk);

    // A byte leaves only when the Tx FIFO has room; in DATA the payload word
    // must also be present, which covers the word-boundary stall.
    assign w_send = w_emit && !i_tx_full && !((r_state == StData) && i_data_empty);

    assign w_last_word_byte = (r_byte_idx == LastWordByte);
    assign w_last_len_byte  = (r_byte_idx == LastLenByte);
    assign w_last_word      = (r_words_left == OneWord);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StIdle: begin
                if (i_start && !i_info_empty) begin
                    w_next_state = StInfo;
                end
            end
            StInfo: w_next_state = StSync;
            StSync: begin
                if (w_send) begin
                    w_next_state = StStat;
                end
            end
            StStat: begin
                if (w_send) begin
                    w_next_state = StLen;
                end
            end
            StLen: begin
                if (w_send && w_last_len_byte) begin
                    w_next_state = (r_length == '0) ? AfterPayload : StData;
                end
            end
            StData: begin
                if (w_send && w_last_word_byte && w_last_word) begin
                    w_next_state = AfterPayload;
                end
            end
            StChk: begin
                if (w_send) begin
                    w_next_state = StDone;
                end
            end
            StDone:  w_next_state = StIdle;
            default: w_next_state = StIdle;
        endcase
    end

    // Outputs decoded from the registered state (start never reaches them)
    always_comb begin
        o_busy    = (r_state != StIdle) && (r_state != StDone);
        o_done    = (r_state == StDone);
        o_info_re = (r_state == StInfo);
        o_data_re = (r_state == StData) && w_send && w_last_word_byte;
        o_tx_send = w_send;
    end

    // Field latches, counters and checksum; all hold while no byte is sent.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_status     <= 8'h00;
            r_length     <= '0;
            r_words_left <= '0;
            r_byte_idx   <= '0;
            r_chk        <= 8'h00;
        end else begin
            case (r_state)
                StInfo: begin
                    r_status     <= i_info_data[INFO_W-1 -: 8];
                    r_length     <= i_info_data[LEN_W-1:0];
                    r_words_left <= i_info_data[LEN_W-1:0];
                    r_byte_idx   <= '0;
                    r_chk        <= 8'h00;
                end
                StStat: begin
                    if (w_send) begin
                        r_chk <= r_chk ^ w_tx_byte;
                    end
                end
                StLen: begin
                    if (w_send) begin
                        r_chk      <= r_chk ^ w_tx_byte;
                        r_byte_idx <= w_last_len_byte ? '0 : r_byte_idx + IdxOne;
                    end
                end
                StData: begin
                    if (w_send) begin
                        r_chk <= r_chk ^ w_tx_byte;
                        if (w_last_word_byte) begin
                            r_byte_idx   <= '0;
                            r_words_left <= r_words_left - OneWord;
                        end else begin
                            r_byte_idx <= r_byte_idx + IdxOne;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    frame_byte_mux #(
        .BPW       (BPW),
        .LEN_W     (LEN_W),
        .BIDX_W    (BidxW),
        .SYNC_BYTE (SYNC_BYTE)
    ) u_frame_byte_mux (
        .i_state    (r_state),
        .i_status   (r_status),
        .i_length   (r_length),
        .i_byte_idx (r_byte_idx),
        .i_data     (i_data),
        .i_chk      (r_chk),
        .o_byte     (w_tx_byte)
    );

    assign o_tx_data = w_tx_byte;

endmodule
